// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use stall,
// branch/jump flushes, ALU forwarding selects, global freeze and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] IDrs,
  input  logic [REG_W-1:0] IDrt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic [REG_W-1:0] IDDest,
  input  logic             IDRegWrite,
  input  logic             IDMemRead,
  input  logic             IDJump,
  input  logic             MEMBranchTaken,
  input  logic             Freeze,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             PipeEnable,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dest_q, ex_dest_d;
  logic             ex_regwrite_q, ex_regwrite_d, ex_memread_q, ex_memread_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d, wb_dest_q, wb_dest_d;
  logic             mem_regwrite_q, mem_regwrite_d, wb_regwrite_q, wb_regwrite_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] m_dest, input logic m_rw,
                                         input logic [REG_W-1:0] w_dest, input logic w_rw);
    if (m_rw && m_dest != '0 && m_dest == src) begin
      return 2'b10;
    end else if (w_rw && w_dest != '0 && w_dest == src) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = ex_memread_q && ex_regwrite_q && (ex_dest_q != '0) &&
                    ((IDUsesRs && IDrs == ex_dest_q) || (IDUsesRt && IDrt == ex_dest_q));

  always_comb begin
    PCWrite        = 1'b1;
    IFIDWrite      = 1'b1;
    IFIDFlush      = 1'b0;
    IDEXFlush      = 1'b0;
    EXMEMFlush     = 1'b0;
    PipeEnable     = 1'b1;
    ForwardA       = fwd_sel(ex_rs_q, mem_dest_q, mem_regwrite_q, wb_dest_q, wb_regwrite_q);
    ForwardB       = fwd_sel(ex_rt_q, mem_dest_q, mem_regwrite_q, wb_dest_q, wb_regwrite_q);
    // Default next state is a normal shift ID -> EX -> MEM -> WB.
    ex_rs_d        = IDrs;
    ex_rt_d        = IDrt;
    ex_dest_d      = IDDest;
    ex_regwrite_d  = IDRegWrite;
    ex_memread_d   = IDMemRead;
    mem_dest_d     = ex_dest_q;
    mem_regwrite_d = ex_regwrite_q;
    wb_dest_d      = mem_dest_q;
    wb_regwrite_d  = mem_regwrite_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;

    if (Reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      EXMEMFlush = 1'b1;
      ForwardA   = 2'b00;
      ForwardB   = 2'b00;
    end else if (Freeze) begin
      PCWrite        = 1'b0;
      IFIDWrite      = 1'b0;
      PipeEnable     = 1'b0;
      ex_rs_d        = ex_rs_q;
      ex_rt_d        = ex_rt_q;
      ex_dest_d      = ex_dest_q;
      ex_regwrite_d  = ex_regwrite_q;
      ex_memread_d   = ex_memread_q;
      mem_dest_d     = mem_dest_q;
      mem_regwrite_d = mem_regwrite_q;
      wb_dest_d      = wb_dest_q;
      wb_regwrite_d  = wb_regwrite_q;
    end else if (MEMBranchTaken) begin
      IFIDFlush      = 1'b1;
      IDEXFlush      = 1'b1;
      EXMEMFlush     = 1'b1;
      ex_rs_d        = '0;
      ex_rt_d        = '0;
      ex_dest_d      = '0;
      ex_regwrite_d  = 1'b0;
      ex_memread_d   = 1'b0;
      mem_dest_d     = '0;
      mem_regwrite_d = 1'b0;
      flush_cnt_d    = sat_inc(flush_cnt_q);
    end else if (load_use) begin
      PCWrite       = 1'b0;
      IFIDWrite     = 1'b0;
      IDEXFlush     = 1'b1;
      ex_rs_d       = '0;
      ex_rt_d       = '0;
      ex_dest_d     = '0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      stall_cnt_d   = sat_inc(stall_cnt_q);
    end else if (IDJump) begin
      IFIDFlush   = 1'b1;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dest_q      <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      wb_dest_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_dest_q      <= wb_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of per-cycle vectors plus
// hand sequences for counter saturation using a narrow-counter second instance.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 5;

  // ctl = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, PipeEnable}
  localparam logic [5:0] CRST = 6'b001111;
  localparam logic [5:0] CNRM = 6'b110001;
  localparam logic [5:0] CSTL = 6'b000101;
  localparam logic [5:0] CBR  = 6'b111111;
  localparam logic [5:0] CJMP = 6'b111001;
  localparam logic [5:0] CFRZ = 6'b000000;

  typedef struct {
    logic             rst, frz, br, jmp;
    logic [REG_W-1:0] rs, rt;
    logic             urs, urt;
    logic [REG_W-1:0] dest;
    logic             rw, mr;
    logic [5:0]       ctl;
    logic [1:0]       fa, fb;
    logic [15:0]      sc, fc;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, frz, br, jmp, urs, urt, rw, mr;
  logic [REG_W-1:0] rs, rt, dest;
  logic             pcw, ifidw, ifidfl, idexfl, exmemfl, pe;
  logic [1:0]       fa, fb;
  logic [15:0]      sc, fc;
  logic             s_pcw, s_ifidw, s_ifidfl, s_idexfl, s_exmemfl, s_pe;
  logic [1:0]       s_fa, s_fb;
  logic [2:0]       s_sc, s_fc;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16), .REG_W(REG_W)) dut (
    .Clk(clk), .Reset(rst), .IDrs(rs), .IDrt(rt), .IDUsesRs(urs), .IDUsesRt(urt),
    .IDDest(dest), .IDRegWrite(rw), .IDMemRead(mr), .IDJump(jmp), .MEMBranchTaken(br),
    .Freeze(frz), .PCWrite(pcw), .IFIDWrite(ifidw), .IFIDFlush(ifidfl), .IDEXFlush(idexfl),
    .EXMEMFlush(exmemfl), .PipeEnable(pe), .ForwardA(fa), .ForwardB(fb),
    .StallCount(sc), .FlushCount(fc)
  );

  // Narrow counters so saturation is reachable in a few cycles.
  pipeline_hazard_ctrl #(.CNT_W(3), .REG_W(REG_W)) dut_small (
    .Clk(clk), .Reset(rst), .IDrs(rs), .IDrt(rt), .IDUsesRs(urs), .IDUsesRt(urt),
    .IDDest(dest), .IDRegWrite(rw), .IDMemRead(mr), .IDJump(jmp), .MEMBranchTaken(br),
    .Freeze(frz), .PCWrite(s_pcw), .IFIDWrite(s_ifidw), .IFIDFlush(s_ifidfl),
    .IDEXFlush(s_idexfl), .EXMEMFlush(s_exmemfl), .PipeEnable(s_pe), .ForwardA(s_fa),
    .ForwardB(s_fb), .StallCount(s_sc), .FlushCount(s_fc)
  );

  function automatic vec_t mk(logic r, logic f, logic b, logic j, int s1, int s2, logic u1,
                              logic u2, int d, logic w, logic m, logic [5:0] c,
                              logic [1:0] a, logic [1:0] bb, int s, int fl);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.jmp = j;
    v.rs = REG_W'(s1); v.rt = REG_W'(s2); v.urs = u1; v.urt = u2;
    v.dest = REG_W'(d); v.rw = w; v.mr = m;
    v.ctl = c; v.fa = a; v.fb = bb; v.sc = 16'(s); v.fc = 16'(fl);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; frz = v.frz; br = v.br; jmp = v.jmp;
    rs = v.rs; rt = v.rt; urs = v.urs; urt = v.urt;
    dest = v.dest; rw = v.rw; mr = v.mr;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  initial begin
    vec_t idle;
    int   stalls;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b00, 2'b00, 0, 0);

    //          rst frz br jmp rs rt urs urt dst rw mr  ctl   fa     fb    sc fc
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CRST, 2'b00, 2'b00, 0, 0));
    // lw $2,0($1) ; add $3,$2,$4 -> one stall, then WB forward
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0, 2, 1, 1, CNRM, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 4, 1, 1, 3, 1, 0, CSTL, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 4, 1, 1, 3, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b01, 2'b00, 1, 0));
    // add $2,$1,$1 ; sub $5,$2,$2 -> MEM forward on both operands
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 2, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 2, 1, 1, 5, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b10, 2'b10, 1, 0));
    // two writers of $2 in MEM and WB -> MEM wins
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 2, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 3, 1, 1, 2, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 7, 1, 1, 6, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b10, 2'b00, 1, 0));
    // lw $0 ; add $3,$0,$0 -> no stall, no forward of $0
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b00, 2'b00, 1, 0));
    // add $7 ; lw $4 ; branch+loaduse+jump ; add $5,$7,$4 -> ex/mem cleared
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 7, 1, 0, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 4, 1, 1, CNRM, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4, 4, 1, 1, 5, 1, 0, CBR,  2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 4, 1, 1, 5, 1, 0, CNRM, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b00, 2'b00, 1, 1));
    // plain jump
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, CJMP, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b00, 2'b00, 1, 2));
    // lw $2 ; freeze x3 over the dependent add (jump deferred) ; stall fires once
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 2, 1, 1, CNRM, 2'b00, 2'b00, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 2, 2, 1, 1, 3, 1, 0, CFRZ, 2'b00, 2'b00, 1, 2));
    vecs.push_back(mk(0, 1, 0, 1, 2, 2, 1, 1, 3, 1, 0, CFRZ, 2'b00, 2'b00, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 2, 2, 1, 1, 3, 1, 0, CFRZ, 2'b00, 2'b00, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 2, 2, 1, 1, 3, 1, 0, CSTL, 2'b00, 2'b00, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 2, 2, 1, 1, 3, 1, 0, CNRM, 2'b00, 2'b00, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b01, 2'b01, 2, 2));
    // branch deferred by freeze, then taken
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, CFRZ, 2'b00, 2'b00, 2, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, CBR,  2'b00, 2'b00, 2, 2));
    // reset in the middle of a load-use stall
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 2, 1, 1, CNRM, 2'b00, 2'b00, 2, 3));
    vecs.push_back(mk(1, 0, 0, 0, 2, 2, 1, 1, 3, 1, 0, CRST, 2'b00, 2'b00, 2, 3));
    vecs.push_back(mk(0, 0, 0, 0, 2, 2, 1, 1, 3, 1, 0, CNRM, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CRST, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b00, 2'b00, 0, 0));

    drive(idle);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("row%0d ctl", i), {pcw, ifidw, ifidfl, idexfl, exmemfl, pe}, vecs[i].ctl);
      check($sformatf("row%0d fwdA", i), fa, vecs[i].fa);
      check($sformatf("row%0d fwdB", i), fb, vecs[i].fb);
      check($sformatf("row%0d stall_cnt", i), sc, vecs[i].sc);
      check($sformatf("row%0d flush_cnt", i), fc, vecs[i].fc);
    end

    // lw $2,0($2) back to back: every other cycle is a load-use stall.
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 2, 0, 1, 0, 2, 1, 1, CNRM, 2'b00, 2'b00, 0, 0));
      #1;
      if (!pcw) stalls++;
    end
    @(negedge clk);
    drive(idle);
    #1;
    check("stall cycles seen", stalls, 10);
    check("stall_cnt wide", sc, 10);
    check("stall_cnt saturated", s_sc, 7);
    check("flush_cnt untouched", s_fc, 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, CNRM, 2'b00, 2'b00, 0, 0));
    end
    @(negedge clk);
    drive(idle);
    #1;
    check("flush_cnt wide", fc, 10);
    check("flush_cnt saturated", s_fc, 7);
    check("stall_cnt holds sat", s_sc, 7);

    // Reset pulse clears saturated counters.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst ctl", {pcw, ifidw, ifidfl, idexfl, exmemfl, pe}, CRST);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst clears stall", s_sc, 0);
    check("rst clears flush", s_fc, 0);
    check("post-rst ctl", {pcw, ifidw, ifidfl, idexfl, exmemfl, pe}, CNRM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
